// File: rtl/pipelined_add_sub.sv
// ---------------------------------------------------------------------------
// pipelined_add_sub
//
// Pipelined two's-complement adder/subtractor. The WIDTH-bit carry chain is
// cut into STAGES slices of SW = WIDTH/STAGES bits. Stage k adds slice k of
// A and B' together with the carry produced by stage k-1, so each stage only
// has an SW-bit carry chain in front of its registers.
//
// Operand conditioning happens as the beat enters stage 0:
//   B' = in_sub ? ~in_b : in_b
//   c0 = in_carry ^ in_sub
// and the result is A + B' + c0 (mod 2^WIDTH). For subtraction in_carry acts
// as a borrow-in and out_carry reads 1 when no borrow occurred.
//
// Every stage carries, next to its valid bit:
//   a_q / b_q : A and B' (upper slices still to be consumed downstream)
//   s_q       : partial sum, slices 0..k already resolved
//   c_q       : carry out of slice k
// The last stage therefore holds the finished sum, the final carry and the
// operand MSBs, from which the flags are derived.
//
// Handshake (both ports): a beat moves on a rising edge where valid and
// ready are both high. A producer holds its beat stable until it moves; the
// consumer side of this block keeps out_* stable while out_valid is high and
// out_ready is low. in_ready depends only on stage state and out_ready, and
// out_valid is a stage valid flop, so in_valid never reaches out_valid
// combinationally.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous reset, active-high, wins over all traffic
//   in_valid      operand beat present
//   in_ready      block accepts a beat this cycle
//   in_a, in_b    operands (WIDTH bits)
//   in_sub        0: A+B+cin, 1: A-B-cin
//   in_carry      carry-in (add) / borrow-in (sub)
//   out_valid     result beat present
//   out_ready     consumer accepts the result this cycle
//   out_sum       result (WIDTH bits)
//   out_carry     carry out of the MSB (sub: 1 = no borrow)
//   out_overflow  signed overflow
//   out_zero      out_sum == 0
// ---------------------------------------------------------------------------
module pipelined_add_sub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_overflow,
    output logic             out_zero
);

    localparam int SW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // -----------------------------------------------------------------------
    // Stage registers
    // -----------------------------------------------------------------------
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] c_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];

    // -----------------------------------------------------------------------
    // Operand conditioning for the stage-0 input
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] b_cond;
    logic             c0;

    always_comb begin
        b_cond = in_sub ? ~in_b : in_b;
        // Subtraction is A + ~B + 1 - borrow, so the injected carry is the
        // inverted borrow.
        c0     = in_carry ^ in_sub;
    end

    // -----------------------------------------------------------------------
    // What each stage would load: stage 0 takes the conditioned input beat,
    // stage k takes the contents of stage k-1.
    // -----------------------------------------------------------------------
    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] src_c;
    logic [WIDTH-1:0]  src_a [STAGES];
    logic [WIDTH-1:0]  src_b [STAGES];
    logic [WIDTH-1:0]  src_s [STAGES];

    always_comb begin
        src_v    = '0;
        src_c    = '0;
        src_v[0] = in_valid;
        src_c[0] = c0;
        src_a[0] = in_a;
        src_b[0] = b_cond;
        src_s[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k] = v_q[k-1];
            src_c[k] = c_q[k-1];
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_s[k] = s_q[k-1];
        end
    end

    // -----------------------------------------------------------------------
    // Load chain. A stage may load when it is empty or when its content moves
    // on in the same edge. Walking from the output backwards lets an empty
    // stage accept even while everything downstream is stalled, which is
    // what collapses bubbles.
    // -----------------------------------------------------------------------
    logic [STAGES-1:0] load;

    always_comb begin
        logic chain;
        load       = '0;
        chain      = !v_q[LAST] || out_ready;
        load[LAST] = chain;
        for (int k = LAST - 1; k >= 0; k--) begin
            chain   = !v_q[k] || chain;
            load[k] = chain;
        end
    end

    // -----------------------------------------------------------------------
    // Per-stage slice add and next-state
    // -----------------------------------------------------------------------
    logic [SW:0] slice_sum [STAGES];

    always_comb begin
        v_d = v_q;
        c_d = c_q;
        for (int k = 0; k < STAGES; k++) begin
            a_d[k]       = a_q[k];
            b_d[k]       = b_q[k];
            s_d[k]       = s_q[k];
            slice_sum[k] = '0;
        end

        for (int k = 0; k < STAGES; k++) begin
            slice_sum[k] = {1'b0, src_a[k][k*SW +: SW]}
                         + {1'b0, src_b[k][k*SW +: SW]}
                         + {{SW{1'b0}}, src_c[k]};
            if (load[k]) begin
                // The valid bit follows the upstream stage even for a bubble;
                // datapath flops only load when a real beat arrives.
                v_d[k] = src_v[k];
                if (src_v[k]) begin
                    a_d[k]                = src_a[k];
                    b_d[k]                = src_b[k];
                    s_d[k]                = src_s[k];
                    s_d[k][k*SW +: SW]    = slice_sum[k][SW-1:0];
                    c_d[k]                = slice_sum[k][SW];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // State registers. Datapath flops are cleared as well so the flags read
    // sum=0, carry=0, overflow=0, zero=1 straight out of reset.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            v_q <= v_d;
            c_q <= c_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs, all taken from last-stage flops so they stay put during a
    // stall. Overflow: operands of equal sign producing a sum of the other
    // sign.
    // -----------------------------------------------------------------------
    always_comb begin
        in_ready     = load[0];
        out_valid    = v_q[LAST];
        out_sum      = s_q[LAST];
        out_carry    = c_q[LAST];
        out_overflow = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1])
                    && (s_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);
        out_zero     = ~|s_q[LAST];
    end

endmodule
